// File: rtl/seq_multicycle_ctrl.sv
// Multi-cycle sequential processor controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// sequencing, register file, PC, status and retired-instruction counter.
// Build option: define SEQ_REG_INIT_EN to reset regs[i] to i instead of 0.
module seq_multicycle_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned RA_W  = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mem_stall,
    input  logic [RA_W-1:0]  srcA,
    input  logic [RA_W-1:0]  srcB,
    output logic [XLEN-1:0]  valA,
    output logic [XLEN-1:0]  valB,
    input  logic [RA_W-1:0]  dstE,
    input  logic [RA_W-1:0]  dstM,
    input  logic [XLEN-1:0]  valE,
    input  logic [XLEN-1:0]  valM,
    input  logic [XLEN-1:0]  new_pc,
    input  logic [2:0]       stat_in,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       stage,
    output logic [2:0]       stat,
    output logic             retire,
    output logic [CNT_W-1:0] icount
);

    // Index 2**RA_W-1 is RNONE: never read, never written.
    localparam int unsigned     NREGS    = (1 << RA_W) - 1;
    localparam logic [RA_W-1:0] RNONE    = '1;
    localparam logic [2:0]      STAT_AOK = 3'd1;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StWriteback = 3'd5,
        StHalted    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q;
    logic [2:0]        stat_q;
    logic [CNT_W-1:0]  icount_q;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic              wb_en;
    logic              halt_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; HALTED only exits through reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (start) state_d = StFetch;
            StFetch:     state_d = StDecode;
            StDecode:    state_d = StExecute;
            StExecute:   state_d = StMemory;
            StMemory: begin
                if (!mem_stall) begin
                    state_d = (stat_in == STAT_AOK) ? StWriteback : StHalted;
                end
            end
            StWriteback: state_d = StFetch;
            StHalted:    state_d = StHalted;
            default:     state_d = StIdle;
        endcase
    end

    // Output / datapath-control decode from the current state
    always_comb begin
        wb_en   = (state_q == StWriteback);
        halt_en = (state_q == StMemory) && !mem_stall && (stat_in != STAT_AOK);
        retire  = wb_en;
        stage   = state_q;
    end

    // PC, status and retire counter; the counter wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            stat_q   <= STAT_AOK;
            icount_q <= '0;
        end else begin
            if (wb_en) begin
                pc_q     <= new_pc;
                icount_q <= icount_q + 1'b1;
            end
            if (halt_en) begin
                stat_q <= stat_in;
            end
        end
    end

    // Register file write-back; the M write is issued last so it wins on dstE == dstM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
`ifdef SEQ_REG_INIT_EN
                regs_q[i] <= XLEN'(i);
`else
                regs_q[i] <= '0;
`endif
            end
        end else if (wb_en) begin
            if (dstE != RNONE) regs_q[dstE] <= valE;
            if (dstM != RNONE) regs_q[dstM] <= valM;
        end
    end

    // Combinational read ports; RNONE matches no entry and reads as zero
    always_comb begin
        valA = '0;
        valB = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (srcA == RA_W'(i)) valA = regs_q[i];
            if (srcB == RA_W'(i)) valB = regs_q[i];
        end
    end

    assign pc     = pc_q;
    assign stat   = stat_q;
    assign icount = icount_q;

endmodule

// File: doc/seq_multicycle_ctrl.md
SEQ_MULTICYCLE_CTRL -- requirements
Module: seq_multicycle_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, the datapath and register width in bits.
REQ-002 SHALL have parameter RA_W, default 4, the register-index width; index 2**RA_W-1 is RNONE, and registers 0..2**RA_W-2 exist.
REQ-003 SHALL have parameter CNT_W, default 32, the width of the retired-instruction counter.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit, which begins execution when sampled in IDLE.
REQ-007 SHALL have port mem_stall, input, 1 bit, which holds the MEMORY stage while high.
REQ-008 SHALL have ports srcA and srcB, inputs, RA_W bits each, the decode read indices.
REQ-009 SHALL have ports valA and valB, outputs, XLEN bits each, the register read data.
REQ-010 SHALL have ports dstE and dstM, inputs, RA_W bits each, the write-back indices.
REQ-011 SHALL have ports valE and valM, inputs, XLEN bits each, the write-back data.
REQ-012 SHALL have port new_pc, input, XLEN bits, the next PC computed by the PC-update logic.
REQ-013 SHALL have port stat_in, input, 3 bits, carrying AOK=1, HLT=2, ADR=3 or INS=4.
REQ-014 SHALL have port pc, output, XLEN bits, the current PC register.
REQ-015 SHALL have port stage, output, 3 bits, encoded IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6.
REQ-016 SHALL have port stat, output, 3 bits, the registered machine status.
REQ-017 SHALL have port retire, output, 1 bit, a one-cycle pulse per committed instruction.
REQ-018 SHALL have port icount, output, CNT_W bits, the count of retired instructions.

Function
REQ-019 SHALL hold state in a 7-state FSM: IDLE -> FETCH on start; FETCH -> DECODE -> EXECUTE -> MEMORY unconditionally, one cycle each.
REQ-020 SHALL stay in MEMORY while mem_stall=1, and leave MEMORY on the first cycle with mem_stall=0.
REQ-021 SHALL, on leaving MEMORY with stat_in=AOK, enter WRITEBACK, then enter FETCH on the following cycle.
REQ-022 SHALL, on leaving MEMORY with stat_in!=AOK, enter HALTED, latch stat<=stat_in, write no register, leave PC unchanged and not assert retire.
REQ-023 SHALL make HALTED terminal: start is ignored and only reset exits it.
REQ-024 SHALL ignore start in every state other than IDLE.
REQ-025 SHALL drive valA/valB combinationally as regs[srcA]/regs[srcB], returning 0 when the index is RNONE.
REQ-026 SHALL, in WRITEBACK, write regs[dstE]<=valE and regs[dstM]<=valM, each skipped when its index is RNONE.
REQ-027 SHALL, when dstE==dstM!=RNONE, write valM only (M priority).
REQ-028 SHALL leave the register file unchanged in every state other than WRITEBACK.
REQ-029 SHALL, in WRITEBACK, load pc<=new_pc, pulse retire for exactly one cycle and increment icount by 1.
REQ-030 SHALL let icount wrap from 2**CNT_W-1 to 0 without a flag.
REQ-031 SHALL give a latency of 5 cycles per instruction plus one cycle per stalled MEMORY cycle.

Reset
REQ-032 SHALL, when rst_n=0, in any state including mid-instruction, immediately force stage=IDLE, pc=0, stat=AOK, retire=0, icount=0.
REQ-033 SHALL reset the register file per REQ-035.
REQ-034 SHALL begin operation after rst_n deasserts only on a subsequent start.

Configuration
REQ-035 SHALL use macro SEQ_REG_INIT_EN: when defined, reset loads regs[i]<=i (zero-extended); when undefined, reset loads every register with 0.

Verification
REQ-036 SHALL cover: SEQ_REG_INIT_EN defined, reset, srcA=3, srcB=RNONE -> valA=3, valB=0.
REQ-037 SHALL cover: start, mem_stall=0, stat_in=AOK, dstE=2, valE=0x55, dstM=RNONE, new_pc=0xA -> 5 cycles later regs[2]=0x55, pc=0xA, one retire pulse, icount=1.
REQ-038 SHALL cover: dstE=dstM=4, valE=0x11, valM=0x22 -> regs[4]=0x22.
REQ-039 SHALL cover: mem_stall high for 3 cycles in MEMORY -> retire 8 cycles after FETCH entry, stage=4 held throughout the stall.
REQ-040 SHALL cover: stat_in=ADR at end of MEMORY -> stage=6, stat=3, no register or pc change, later start ignored.
REQ-041 SHALL cover: rst_n pulsed low during EXECUTE -> stage=0, pc=0, icount=0 asynchronously, before the next clk edge.
